// File: rtl/set_replace_ctrl.sv
// ---------------------------------------------------------------------------
// set_replace_ctrl
//   Hit detection and victim selection for one set of a set-associative
//   cache. Supports LRU, LFU (saturating counters with aging) and FIFO
//   replacement, selectable at run time. Invalid ways are always filled first.
//
// Ports
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_en                lookup valid; policy update commits at posedge
//   i_fill              refill of o_victim_way completes this cycle
//   i_mode              0=LRU 1=LFU 2=FIFO 3=LRU
//   i_wen               store request, routed to o_line_wen
//   i_addr_tag          lookup tag
//   i_line_tag/valid/dirty/data   per-way tag, valid, dirty, data (way i at
//                       slice i of each packed bus)
//   o_hit, o_hit_way    hit flag and lowest matching way
//   o_victim_way        way to replace
//   o_dirty, o_read_data, o_replace_tag   fields of hit way, else victim way
//   o_line_wen          one-hot write enable
// ---------------------------------------------------------------------------
module set_replace_ctrl #(
   parameter int TAG_WIDTH  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LINES      = 4,
   parameter int CNT_WIDTH  = 4,
   parameter int WAY_W      = $clog2(LINES)
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_en,
   input  logic                        i_fill,
   input  logic [1:0]                  i_mode,
   input  logic                        i_wen,
   input  logic [TAG_WIDTH-1:0]        i_addr_tag,
   input  logic [LINES*TAG_WIDTH-1:0]  i_line_tag,
   input  logic [LINES-1:0]            i_line_valid,
   input  logic [LINES-1:0]            i_line_dirty,
   input  logic [LINES*DATA_WIDTH-1:0] i_line_data,
   output logic                        o_hit,
   output logic                        o_dirty,
   output logic [WAY_W-1:0]            o_hit_way,
   output logic [WAY_W-1:0]            o_victim_way,
   output logic [LINES-1:0]            o_line_wen,
   output logic [DATA_WIDTH-1:0]       o_read_data,
   output logic [TAG_WIDTH-1:0]        o_replace_tag
);

   localparam logic [1:0] MODE_LFU  = 2'd1;
   localparam logic [1:0] MODE_FIFO = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   // Value of the hit way after aging: halved maximum plus the hit itself.
   localparam logic [CNT_WIDTH-1:0] CNT_AGED = (CNT_MAX >> 1) + 1'b1;

   logic [CNT_WIDTH-1:0] r_cnt [LINES];
   logic [WAY_W-1:0]     r_fifo_ptr;
   logic [1:0]           r_mode_q;

   logic [CNT_WIDTH-1:0] w_cnt_next [LINES];
   logic [WAY_W-1:0]     w_fifo_ptr_next;
   logic [1:0]           w_mode_next;

   logic                 w_hit;
   logic [WAY_W-1:0]     w_hit_way;
   logic [WAY_W-1:0]     w_inv_way;
   logic [WAY_W-1:0]     w_max_way;
   logic [WAY_W-1:0]     w_min_way;
   logic [WAY_W-1:0]     w_victim_way;
   logic [WAY_W-1:0]     w_sel_way;
   logic [CNT_WIDTH-1:0] w_max_cnt;
   logic [CNT_WIDTH-1:0] w_min_cnt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   // Hit / invalid search: scanning downward leaves the lowest index.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_inv_way = '0;
      for (int i = LINES - 1; i >= 0; i--) begin
         if (i_line_valid[i] && (i_line_tag[i*TAG_WIDTH +: TAG_WIDTH] == i_addr_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(i);
         end
         if (!i_line_valid[i])
            w_inv_way = WAY_W'(i);
      end
   end

   // Max/min search: strict compares on an upward scan keep the lowest index on ties.
   always_comb begin
      w_max_cnt = r_cnt[0];
      w_min_cnt = r_cnt[0];
      w_max_way = '0;
      w_min_way = '0;
      for (int i = 1; i < LINES; i++) begin
         if (r_cnt[i] > w_max_cnt) begin
            w_max_cnt = r_cnt[i];
            w_max_way = WAY_W'(i);
         end
         if (r_cnt[i] < w_min_cnt) begin
            w_min_cnt = r_cnt[i];
            w_min_way = WAY_W'(i);
         end
      end
   end

   always_comb begin
      if (!(&i_line_valid))
         w_victim_way = w_inv_way;
      else begin
         case (r_mode_q)
            MODE_LFU:  w_victim_way = w_min_way;
            MODE_FIFO: w_victim_way = r_fifo_ptr;
            default:   w_victim_way = w_max_way;
         endcase
      end
   end

   assign w_sel_way     = w_hit ? w_hit_way : w_victim_way;
   assign o_hit         = w_hit;
   assign o_hit_way     = w_hit_way;
   assign o_victim_way  = w_victim_way;
   assign o_dirty       = i_line_dirty[w_sel_way];
   assign o_read_data   = i_line_data[w_sel_way*DATA_WIDTH +: DATA_WIDTH];
   assign o_replace_tag = i_line_tag[w_sel_way*TAG_WIDTH +: TAG_WIDTH];
   assign o_line_wen    = i_wen ? (LINES'(1) << w_sel_way) : '0;

   // Policy update. Mode change outranks fill, which outranks a lookup hit.
   always_comb begin
      w_cnt_next      = r_cnt;
      w_fifo_ptr_next = r_fifo_ptr;
      w_mode_next     = r_mode_q;
      if (i_mode != r_mode_q) begin
         for (int i = 0; i < LINES; i++)
            w_cnt_next[i] = '0;
         w_fifo_ptr_next = '0;
         w_mode_next     = i_mode;
      end else if (i_fill) begin
         case (r_mode_q)
            MODE_LFU:  w_cnt_next[w_victim_way] = CNT_WIDTH'(1);
            MODE_FIFO: w_fifo_ptr_next = r_fifo_ptr + 1'b1;  // LINES is 2^WAY_W, wraps naturally
            default: begin
               for (int i = 0; i < LINES; i++)
                  w_cnt_next[i] = (WAY_W'(i) == w_victim_way) ? '0 : sat_inc(r_cnt[i]);
            end
         endcase
      end else if (i_en && w_hit) begin
         case (r_mode_q)
            MODE_LFU: begin
               if (r_cnt[w_hit_way] == CNT_MAX) begin
                  for (int i = 0; i < LINES; i++)
                     w_cnt_next[i] = r_cnt[i] >> 1;
                  w_cnt_next[w_hit_way] = CNT_AGED;
               end else
                  w_cnt_next[w_hit_way] = r_cnt[w_hit_way] + 1'b1;
            end
            MODE_FIFO: ;
            default: begin
               for (int i = 0; i < LINES; i++) begin
                  if (WAY_W'(i) == w_hit_way)
                     w_cnt_next[i] = '0;
                  else if (i_line_valid[i])
                     w_cnt_next[i] = sat_inc(r_cnt[i]);
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < LINES; i++)
            r_cnt[i] <= '0;
         r_fifo_ptr <= '0;
         r_mode_q   <= '0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_fifo_ptr <= w_fifo_ptr_next;
         r_mode_q   <= w_mode_next;
      end
   end

endmodule

// File: doc/set_replace_ctrl.md
Name: set_replace_ctrl

Overview:
- Per-set hit detection and victim selection for the set-associative cache.
- Generalises the fixed 4-way LFU controller: any power-of-two way count, configurable tag and data width, and run-time choice of LRU, LFU or FIFO.
- LFU uses saturating counters with aging.
- Invalid ways are filled first.
- Sits between the tag/data arrays of one set and the cache FSM. The FSM drives en per lookup and fill per refill.

Parameters:
- TAG_WIDTH, `CACHE_T, tag bits per line
- DATA_WIDTH, 32, bits per data word
- LINES, `CACHE_E, number of ways; power of two, 2..16
- CNT_WIDTH, 4, per-way policy counter width
- WAY_W, $clog2(LINES), way-index width (derived; do not override)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  lookup valid this cycle; commits policy update at posedge
- fill  in  1  refill of victim_way completes this cycle
- mode  in  2  0=LRU, 1=LFU, 2=FIFO, 3=reserved (behaves as LRU)
- wen  in  1  store request
- addr_tag  in  TAG_WIDTH  lookup tag
- line_tag  in  LINES*TAG_WIDTH  tags; way i occupies bits [i*TAG_WIDTH +: TAG_WIDTH]
- line_valid  in  LINES  valid bits
- line_dirty  in  LINES  dirty bits
- line_data  in  LINES*DATA_WIDTH  data words, packed as line_tag
- hit  out  1  a valid way matches addr_tag
- dirty  out  1  dirty bit of the hit way, else of the victim way
- hit_way  out  WAY_W  matching way (lowest index if several)
- victim_way  out  WAY_W  way to replace
- line_wen  out  LINES  one-hot: wen routed to hit_way on hit, to victim_way on miss
- read_data  out  DATA_WIDTH  data of the hit way, else of the victim way
- replace_tag  out  TAG_WIDTH  tag of the hit way, else of the victim way (writeback address)

Behaviour:
- All outputs are combinational from inputs and policy state; zero-cycle lookup latency. State changes only at posedge clk.
- State per way: cnt[i], CNT_WIDTH bits. Also fifo_ptr (WAY_W bits) and mode_q (2 bits).
- Reset (asynchronous): cnt[i]=0, fifo_ptr=0, mode_q=0. With all ways invalid, outputs are hit=0, victim_way=0, line_wen=0 if wen=0.
- Victim selection, in priority order:
  - (a) Any invalid way: lowest-index invalid way.
  - (b) LRU: way with maximum cnt.
  - (c) LFU: way with minimum cnt.
  - (d) FIFO: fifo_ptr.
  - Ties resolve to the lowest index.
- Mode change: when mode != mode_q at posedge, clear all cnt and fifo_ptr, load mode_q=mode, and ignore en/fill that cycle. Victim selection uses mode_q.
- Update on en & hit & !fill:
  - LRU: cnt[hit_way]=0; every other valid way saturating +1.
  - LFU: cnt[hit_way] saturating +1. If cnt[hit_way] already equals 2^CNT_WIDTH-1, all cnt shift right by one and cnt[hit_way] is then incremented (aging).
  - FIFO: no change.
- en & !hit: no state change. The FSM performs the refill and raises fill.
- Update on fill, applied to v = victim_way:
  - LRU: cnt[v]=0; others saturating +1.
  - LFU: cnt[v]=1.
  - FIFO: fifo_ptr = fifo_ptr+1, wrapping from LINES-1 to 0.
- fill and en in the same cycle: fill wins; en does not update state.
- Counters never wrap. Saturation holds at all-ones.
- Reset asserted mid-refill clears state immediately. A subsequent fill is handled normally against the reset state.

Test Plan:
- LINES=4, reset, all invalid, wen=1 → hit=0, victim_way=0, line_wen=4'b0001. Set valid[0], en with a miss → victim_way=1.
- LRU, all valid, tags A..D: hits on ways 0,1,2,3, then 0 → cnt = {3:1, 2:2, 1:3, 0:0}, victim_way=1. Hit on way 1 with wen=1 → line_wen=4'b0010, read_data=line_data[1].
- LFU, CNT_WIDTH=4: 15 hits on way 2 then 1 more → cnt[2]=8 after aging (15>>1 = 7, then +1), other ways halved. Victim is the lowest-index way with minimum cnt.
- FIFO, all valid: 5 fill pulses → victim_way sequence 0,1,2,3,0, wrapping.
- Simultaneous en (hit way 3) and fill in LRU → only the fill update occurs; cnt[3] increments rather than clearing.
- Change mode from 1 to 0 with nonzero counters → next cycle all cnt=0, victim_way=0. Assert reset mid-sequence → state cleared asynchronously before the next clk edge.
